// File: rtl/nv_nvdla_sdp_xrdma_arb.sv
// nv_nvdla_sdp_xrdma_arb
//   Arbitrates DMA read requests from NUM_SRC sources onto one DMA read port
//   and routes the in-order response beats back to the source that issued
//   each request. Outstanding requests are limited to LAT_DEPTH credits.
//   A small IDLE/RUN/DRAIN FSM tracks one layer: it starts on op_en, drains
//   once every enabled source has signalled end-of-stream, and pulses
//   layer_done when the last outstanding response returns.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   op_en, src_en, perf_en           : layer start, source enable mask, stall count enable
//   src_req_* / src_eos              : per-source request channel and end-of-stream
//   src_rsp_*                        : per-source response valid/ready, shared payload
//   dma_rd_req_* / dma_rd_rsp_*      : DMA read request and response channels
//   dma_rd_cdt_lat_fifo_pop          : one-cycle credit return per consumed response
//   layer_done, dp2reg_stall, busy   : status
//
// Configuration
//   NVDLA_SDP_XRDMA_QOS_EN : when defined, source 0 has strict priority and the
//                            remaining sources share round-robin; otherwise pure
//                            round-robin across all sources.

module nv_nvdla_sdp_xrdma_arb #(
    parameter int NUM_SRC   = 2,
    parameter int REQ_W     = 79,
    parameter int RSP_W     = 514,
    parameter int LAT_DEPTH = 64
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     op_en,
    input  logic [NUM_SRC-1:0]       src_en,
    input  logic                     perf_en,
    input  logic [NUM_SRC-1:0]       src_req_vld,
    output logic [NUM_SRC-1:0]       src_req_rdy,
    input  logic [NUM_SRC*REQ_W-1:0] src_req_pd,
    input  logic [NUM_SRC-1:0]       src_eos,
    output logic [NUM_SRC-1:0]       src_rsp_vld,
    input  logic [NUM_SRC-1:0]       src_rsp_rdy,
    output logic [RSP_W-1:0]         src_rsp_pd,
    output logic                     dma_rd_req_vld,
    input  logic                     dma_rd_req_rdy,
    output logic [REQ_W-1:0]         dma_rd_req_pd,
    input  logic                     dma_rd_rsp_vld,
    output logic                     dma_rd_rsp_rdy,
    input  logic [RSP_W-1:0]         dma_rd_rsp_pd,
    output logic                     dma_rd_cdt_lat_fifo_pop,
    output logic                     layer_done,
    output logic [31:0]              dp2reg_stall,
    output logic                     busy
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(LAT_DEPTH);
    localparam int OUT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] eos_q;
    logic [SRC_W-1:0]   rr_ptr;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   outstanding_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [SRC_W-1:0]   order_fifo [LAT_DEPTH];
    logic               alive;

    logic [NUM_SRC-1:0] grant_elig;
    logic [NUM_SRC-1:0] rr_elig;
    logic [SRC_W-1:0]   win;
    logic               found;
    logic               credit_ok;
    logic               accept;
    logic               req_any;
    logic               all_eos;
    logic               fifo_empty;
    logic [SRC_W-1:0]   head;
    logic               rsp_hs;
    logic               stall_inc;

    assign req_any    = |(src_req_vld & src_en);
    assign grant_elig = (state == RUN) ? (src_req_vld & src_en) : '0;
    assign credit_ok  = outstanding < OUT_W'(LAT_DEPTH);
    assign all_eos    = &(eos_q | src_eos | ~src_en);

    // Round-robin search starting at rr_ptr; with QoS enabled source 0 is
    // removed from the rotation and overrides it when requesting.
    always_comb begin
        int unsigned sum;
        rr_elig = grant_elig;
`ifdef NVDLA_SDP_XRDMA_QOS_EN
        rr_elig[0] = 1'b0;
`endif
        win   = '0;
        found = 1'b0;
        sum   = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NUM_SRC) sum = sum - NUM_SRC;
            if (!found && rr_elig[SRC_W'(sum)]) begin
                found = 1'b1;
                win   = SRC_W'(sum);
            end
        end
`ifdef NVDLA_SDP_XRDMA_QOS_EN
        if (grant_elig[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

    always_comb begin
        src_req_rdy    = '0;
        dma_rd_req_vld = found & credit_ok;
        dma_rd_req_pd  = '0;
        if (dma_rd_req_vld) begin
            dma_rd_req_pd    = src_req_pd[int'(win)*REQ_W +: REQ_W];
            src_req_rdy[win] = dma_rd_req_rdy;
        end
    end

    assign accept = dma_rd_req_vld & dma_rd_req_rdy;

    // Response routing follows the order FIFO head; with no tag pending the
    // beat is swallowed so a stray response cannot stall the DMA port.
    assign fifo_empty = (outstanding == '0);
    assign head       = order_fifo[rd_ptr];
    assign src_rsp_pd = dma_rd_rsp_pd;

    always_comb begin
        src_rsp_vld    = '0;
        dma_rd_rsp_rdy = alive;
        if (!fifo_empty) begin
            src_rsp_vld[head] = dma_rd_rsp_vld;
            dma_rd_rsp_rdy    = src_rsp_rdy[head];
        end
    end

    assign rsp_hs = dma_rd_rsp_vld & dma_rd_rsp_rdy & ~fifo_empty;

    always_comb begin
        outstanding_nxt = outstanding;
        case ({accept, rsp_hs})
            2'b10:   outstanding_nxt = outstanding + OUT_W'(1);
            2'b01:   outstanding_nxt = outstanding - OUT_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    assign stall_inc = perf_en & (state != IDLE) & req_any & ~accept;
    assign busy      = (state != IDLE);

    // Tag storage carries no reset; validity is tracked by outstanding/pointers.
    always_ff @(posedge nvdla_core_clk) begin
        if (accept) order_fifo[wr_ptr] <= win;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state                   <= IDLE;
            eos_q                   <= '0;
            rr_ptr                  <= '0;
            outstanding             <= '0;
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            alive                   <= 1'b0;
            dp2reg_stall            <= '0;
            dma_rd_cdt_lat_fifo_pop <= 1'b0;
            layer_done              <= 1'b0;
        end else begin
            alive                   <= 1'b1;
            layer_done              <= 1'b0;
            dma_rd_cdt_lat_fifo_pop <= rsp_hs;
            outstanding             <= outstanding_nxt;
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rsp_hs) rd_ptr <= rd_ptr + PTR_W'(1);
            if (stall_inc && (dp2reg_stall != '1)) dp2reg_stall <= dp2reg_stall + 32'd1;

            case (state)
                IDLE: begin
                    if (op_en) begin
                        state        <= RUN;
                        eos_q        <= '0;
                        rr_ptr       <= '0;
                        dp2reg_stall <= '0;
                    end
                end
                RUN: begin
                    eos_q <= eos_q | src_eos;
                    if (accept) begin
                        rr_ptr <= (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + SRC_W'(1);
                    end
                    if (all_eos) state <= DRAIN;
                end
                DRAIN: begin
                    if (outstanding_nxt == '0) begin
                        state      <= IDLE;
                        layer_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nv_nvdla_sdp_xrdma_arb.md
NV_NVDLA_SDP_XRDMA_ARB -- requirements
Module: nv_nvdla_sdp_xrdma_arb

Interface
REQ-001 Parameter NUM_SRC, default 2, SHALL set the number of request sources (legal 2..4).
REQ-002 Parameter REQ_W, default 79, SHALL set the DMA read request payload width.
REQ-003 Parameter RSP_W, default 514, SHALL set the DMA read response payload width.
REQ-004 Parameter LAT_DEPTH, default 64, SHALL set the outstanding-credit limit (power of 2, 4..256).
REQ-005 Ports, in order: nvdla_core_clk in 1 clock; nvdla_core_rstn in 1 reset, asynchronous, active-low (clock nvdla_core_clk).
REQ-006 Ports: op_en in 1 layer start; src_en in NUM_SRC source enable mask; perf_en in 1 stall counting enable.
REQ-007 Ports: src_req_vld in NUM_SRC; src_req_rdy out NUM_SRC; src_req_pd in NUM_SRC*REQ_W; src_eos in NUM_SRC (source issued its last request this cycle).
REQ-008 Ports: src_rsp_vld out NUM_SRC; src_rsp_rdy in NUM_SRC; src_rsp_pd out RSP_W (shared).
REQ-009 Ports: dma_rd_req_vld out 1; dma_rd_req_rdy in 1; dma_rd_req_pd out REQ_W; dma_rd_rsp_vld in 1; dma_rd_rsp_rdy out 1; dma_rd_rsp_pd in RSP_W; dma_rd_cdt_lat_fifo_pop out 1.
REQ-010 Ports: layer_done out 1 (one-cycle pulse); dp2reg_stall out 32; busy out 1.

Function
REQ-011 FSM states IDLE, RUN, DRAIN; IDLE->RUN when op_en; RUN->DRAIN when every src_en source has signalled eos; DRAIN->IDLE when outstanding==0, asserting layer_done for that one cycle.
REQ-012 op_load = op_en in IDLE; op_load SHALL clear eos flags, stall counter and arbiter pointer.
REQ-013 In RUN, round-robin arbitration among sources with src_req_vld & src_en; pointer advances to one past the winner only on an accepted request.
REQ-014 Grant SHALL be issued only when outstanding < LAT_DEPTH; dma_rd_req_vld = any eligible request & credit available; src_req_rdy[w] = grant[w] & dma_rd_req_rdy; all others 0.
REQ-015 Request path SHALL be combinational (zero latency); dma_rd_req_pd = winner's pd, 0 when idle.
REQ-016 Each accepted request SHALL push the winner index into an order FIFO (depth LAT_DEPTH) and increment outstanding.
REQ-017 Each request returns exactly one response beat, in order; the FIFO head selects the destination source.
REQ-018 src_rsp_vld[head] = dma_rd_rsp_vld; dma_rd_rsp_rdy = src_rsp_rdy[head]; src_rsp_pd = dma_rd_rsp_pd.
REQ-019 On response handshake: pop FIFO, decrement outstanding, pulse dma_rd_cdt_lat_fifo_pop for one cycle (registered, one cycle after handshake).
REQ-020 Simultaneous accept and response SHALL leave outstanding unchanged; outstanding width clog2(LAT_DEPTH)+1.
REQ-021 Response with empty order FIFO SHALL be dropped (rdy=1) and not alter outstanding.
REQ-022 Stall counter increments when perf_en, state RUN/DRAIN, and any eligible request is not accepted; saturates at 0xFFFFFFFF.
REQ-023 busy = state != IDLE.
REQ-024 Requests arriving in DRAIN or IDLE SHALL not be granted.

Reset
REQ-025 Asynchronous reset SHALL force: state IDLE, outstanding 0, FIFO empty, pointer 0, eos flags 0, stall 0, all vld/rdy/pop/done outputs 0.
REQ-026 Reset mid-operation SHALL discard in-flight order tags; no credit pop is issued for them.

Configuration
REQ-027 Macro NVDLA_SDP_XRDMA_QOS_EN: defined -> source 0 has strict priority over round-robin among the rest; undefined -> pure round-robin across all sources.

Verification
REQ-028 NUM_SRC=2, both sources request continuously, dma ready -> grants alternate 0,1,0,1; eos both -> layer_done after last response.
REQ-029 LAT_DEPTH=4, responses withheld -> exactly 4 requests accepted, then dma_rd_req_vld=0, stall increments each cycle with perf_en=1.
REQ-030 Issue src0,src1,src1,src0 -> responses routed to src_rsp_vld bits 0,1,1,0 in order, 4 cdt pops.
REQ-031 Accept and response in same cycle at outstanding=3 -> outstanding stays 3.
REQ-032 src_en=2'b10, src1 eos, outstanding 2 -> DRAIN; layer_done pulses exactly one cycle after second response handshake cycle completes drain.
REQ-033 With NVDLA_SDP_XRDMA_QOS_EN, three sources valid -> source 0 wins every cycle until it drops vld.
